mips_program_loader: RTL and testbench

Upstream boot block for the two-phase MIPS core. It accepts a valid/ready stream of 32-bit words and decodes it into blocks: a header, data words and a checksum. It writes each data word into core memory and holds the core until a terminator header arrives. The core is released only after a clean load, replacing bench-side direct writes to Mem/PC/halted.

---
 rtl/mips_program_loader.sv | 118 +++++++++++
 tb/tb_mips_program_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_program_loader.sv
// Boot loader for the two-phase MIPS core: decodes a header/data/checksum word stream
// into core memory writes and holds the core until a terminator follows a clean load.
module mips_program_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  core_hold,
   output logic                  load_done,
   output logic                  load_error,
   output logic [15:0]           words_written
);

   typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERR} state_t;

   localparam logic [16:0] MEM_WORDS = 17'd1 << ADDR_WIDTH;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   csum;
   logic [15:0]             remaining;
   logic [ADDR_WIDTH-1:0]   addr_ptr;

   logic        accept;
   logic [15:0] hdr_count;
   logic [15:0] hdr_base;
   logic [16:0] hdr_end;
   logic        hdr_range_err;

   assign accept    = in_valid && in_ready;
   assign hdr_count = in_data[31:16];
   assign hdr_base  = in_data[15:0];
   // End address is formed one bit wider so a block cannot wrap past the top of memory.
   assign hdr_end       = {1'b0, hdr_base} + {1'b0, hdr_count};
   assign hdr_range_err = ((hdr_base >> ADDR_WIDTH) != 16'd0) || (hdr_end > MEM_WORDS);

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= HDR;
         in_ready      <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         core_hold     <= 1'b1;
         load_done     <= 1'b0;
         load_error    <= 1'b0;
         words_written <= 16'd0;
         csum          <= '0;
         remaining     <= 16'd0;
         addr_ptr      <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            HDR: begin
               in_ready <= 1'b1;
               if (accept) begin
                  if (hdr_count == 16'd0) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     core_hold <= 1'b0;
                     load_done <= 1'b1;
                  end else if (hdr_range_err) begin
                     state      <= ERR;
                     in_ready   <= 1'b0;
                     load_error <= 1'b1;
                  end else begin
                     addr_ptr  <= hdr_base[ADDR_WIDTH-1:0];
                     remaining <= hdr_count;
                     csum      <= in_data;
                     state     <= DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  mem_we        <= 1'b1;
                  mem_addr      <= addr_ptr;
                  mem_wdata     <= in_data;
                  addr_ptr      <= addr_ptr + 1'b1;
                  remaining     <= remaining - 16'd1;
                  csum          <= csum ^ in_data;
                  words_written <= sat_inc(words_written);
                  if (remaining == 16'd1) state <= CSUM;
               end
            end
            CSUM: begin
               if (accept) begin
                  if (in_data == csum) begin
                     state <= HDR;
                  end else begin
                     state      <= ERR;
                     in_ready   <= 1'b0;
                     load_error <= 1'b1;
                  end
               end
            end
            DONE: in_ready <= 1'b0;
            ERR:  in_ready <= 1'b0;
            default: begin
               state      <= ERR;
               in_ready   <= 1'b0;
               load_error <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_program_loader.sv
// Scoreboard bench for mips_program_loader: a stream-level model predicts writes and
// final status; a monitor compares every memory write as the DUT presents it.
module tb_mips_program_loader;
   localparam int AW = 10;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_data = 32'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        core_hold;
   logic        load_done;
   logic        load_error;
   logic [15:0] words_written;

   mips_program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_hold(core_hold), .load_done(load_done), .load_error(load_error),
      .words_written(words_written)
   );

   always #5 clock = ~clock;

   typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;

   int          checks = 0;
   int          errors = 0;
   wr_t         exp_q[$];
   logic [31:0] stream[$];
   logic [31:0] blk[$];
   logic [31:0] prog[8];
   int          m_acc, m_res, m_ww;
   logic        prev_valid;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference model: walk the whole stream by the format rules.
   // m_res: 0 = incomplete, 1 = done, 2 = error. m_acc = words the loader will accept.
   task automatic model();
      int idx = 0;
      m_res = 0;
      m_ww = 0;
      while (idx < stream.size()) begin
         logic [31:0] hdr;
         logic [31:0] x;
         int cnt, base;
         hdr = stream[idx]; idx++;
         cnt = int'(hdr[31:16]);
         base = int'(hdr[15:0]);
         if (cnt == 0) begin m_res = 1; break; end
         if (base >= 1024 || base + cnt > 1024) begin m_res = 2; break; end
         x = hdr;
         for (int i = 0; i < cnt && idx < stream.size(); i++) begin
            wr_t w;
            w.a = AW'(base + i);
            w.d = stream[idx];
            exp_q.push_back(w);
            x = x ^ stream[idx];
            idx++;
            m_ww++;
         end
         if (idx >= stream.size()) break;
         if (stream[idx] != x) begin idx++; m_res = 2; break; end
         idx++;
      end
      m_acc = idx;
   endtask

   task automatic add_block(input int base, input int corrupt);
      logic [31:0] x;
      x = {16'(blk.size()), 16'(base)};
      stream.push_back(x);
      foreach (blk[i]) begin
         stream.push_back(blk[i]);
         x = x ^ blk[i];
      end
      stream.push_back(corrupt != 0 ? x ^ 32'h0000_0100 : x);
   endtask

   always @(posedge clock) prev_valid <= in_valid;

   always @(negedge clock) begin
      if (!reset) begin
         if (mem_we) begin
            check("write_after_stall", 32'(prev_valid), 32'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
               wr_t w;
               w = exp_q.pop_front();
               check("write_addr", 32'(mem_addr), 32'(w.a));
               check("write_data", mem_wdata, w.d);
            end
         end
         check("done_err_exclusive", 32'(load_done & load_error), 32'd0);
      end
   end

   task automatic apply_reset();
      @(negedge clock);
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_core_hold", 32'(core_hold), 32'd1);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_load_error", 32'(load_error), 32'd0);
      check("rst_words_written", 32'(words_written), 32'd0);
      exp_q.delete();
      @(negedge clock);
      reset = 1'b0;
      check("ready_before_edge", 32'(in_ready), 32'd0);
      @(negedge clock);
      check("ready_after_edge", 32'(in_ready), 32'd1);
   endtask

   // Sends stream[0..n-1]; each word is held until it is accepted. Called at a negedge.
   task automatic send_words(input int n, input int stall_pct);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         logic seen;
         while ($urandom_range(99) < 32'(stall_pct)) begin
            in_valid = 1'b0;
            @(negedge clock);
         end
         in_valid = 1'b1;
         in_data = stream[i];
         forever begin
            seen = in_ready;
            @(posedge clock);
            if (seen) break;
            t++;
            @(negedge clock);
            if (t > 50) break;
         end
         if (t > 50) begin
            check("accept_timeout", 32'(i), 32'hFFFF_FFFF);
            in_valid = 1'b0;
            return;
         end
         @(negedge clock);
         in_valid = 1'b0;
      end
   endtask

   task automatic run_stream(input int stall_pct, input string tag);
      apply_reset();
      model();
      check({tag, "_done_before"}, 32'(load_done), 32'd0);
      send_words(m_acc, stall_pct);
      check({tag, "_load_done"}, 32'(load_done), 32'(m_res == 1));
      check({tag, "_core_hold"}, 32'(core_hold), 32'(m_res != 1));
      check({tag, "_load_error"}, 32'(load_error), 32'(m_res == 2));
      check({tag, "_in_ready"}, 32'(in_ready), 32'(m_res == 0));
      // Extra words after the outcome must be ignored.
      if (m_res != 0) begin
         in_valid = 1'b1;
         in_data = 32'h0001_0005;
         repeat (3) @(negedge clock);
         in_valid = 1'b0;
      end
      repeat (2) @(negedge clock);
      check({tag, "_words_written"}, 32'(words_written), 32'(m_ww));
      check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_done_after"}, 32'(load_done), 32'(m_res == 1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      prog[0] = 32'h8C01_0078; prog[1] = 32'h8C02_0079; prog[2] = 32'h0022_1820;
      prog[3] = 32'hAC03_0079; prog[4] = 32'h0000_0000; prog[5] = 32'h0800_0005;
      prog[6] = 32'hFC00_0000; prog[7] = 32'h0000_0000;

      // Single block from the test plan
      stream.delete();
      stream.push_back(32'h0001_0078); stream.push_back(32'h0000_0055);
      stream.push_back(32'h0001_002D); stream.push_back(32'h0000_0000);
      run_stream(0, "single");

      // Program block, back-to-back then with random stalls
      for (int pass = 0; pass < 2; pass++) begin
         stream.delete(); blk.delete();
         foreach (prog[i]) blk.push_back(prog[i]);
         add_block(0, 0);
         stream.push_back(32'h0);
         run_stream(pass == 0 ? 0 : 40, pass == 0 ? "prog" : "prog_stall");
      end

      // Bad checksum
      stream.delete();
      stream.push_back(32'h0001_0078); stream.push_back(32'h0000_0055);
      stream.push_back(32'h0000_0000);
      run_stream(0, "badsum");

      // Range errors
      stream.delete(); stream.push_back(32'h0002_03FF);
      run_stream(0, "range_wrap");
      stream.delete(); stream.push_back(32'h0001_0400);
      run_stream(0, "range_base");
      stream.delete(); blk.delete(); blk.push_back(32'hDEAD_BEEF);
      add_block(1023, 0); stream.push_back(32'h0);
      run_stream(0, "top_word");

      // Reset in the middle of DATA, then a full reload
      stream.delete(); blk.delete();
      foreach (prog[i]) blk.push_back(prog[i]);
      add_block(0, 0);
      stream.push_back(32'h0);
      apply_reset();
      model();
      send_words(4, 0);
      @(negedge clock);
      check("mid_pending", 32'(exp_q.size()), 32'd5);
      check("mid_words_written", 32'(words_written), 32'd3);
      run_stream(0, "reload");

      // Randomized multi-block streams, some corrupted or out of range
      for (int it = 0; it < 12; it++) begin
         int nb;
         stream.delete();
         nb = int'($urandom_range(1, 3));
         for (int b = 0; b < nb; b++) begin
            int cnt, base;
            blk.delete();
            cnt = int'($urandom_range(1, 6));
            base = ($urandom_range(7) == 0) ? int'($urandom_range(1018, 1100))
                                            : int'($urandom_range(0, 1024 - cnt));
            for (int k = 0; k < cnt; k++) blk.push_back($urandom);
            add_block(base, ($urandom_range(5) == 0) ? 1 : 0);
         end
         stream.push_back(32'h0);
         run_stream(int'($urandom_range(0, 50)), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
